// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RISC-V pipeline: PC select, stage enables/flushes,
// forwarding selects and a watchdogged MDU sequencer. Optional perf counters under PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MDU_MAX_CYC = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_mdu_op,
  input  logic              ex_redirect,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              mem_reg_write,
  input  logic              wb_reg_write,
  input  logic              mdu_done,
  output logic              pc_sel,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mdu_start,
  output logic              mdu_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_mdu_cnt
`endif
);

  localparam int CNT_W = (MDU_MAX_CYC > 2) ? $clog2(MDU_MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_MAX_CYC - 1);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MDU_WAIT  = 2'd1,
    S_MDU_DRAIN = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic rs1_hit, rs2_hit, load_use, redirect_run;

  // x0 is hard-wired zero, so a write to it is never a real producer
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] m_rd,
    input logic              m_we,
    input logic [REG_AW-1:0] w_rd,
    input logic              w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != '0) && (m_rd == rs))
      sel = 2'b01;
    else if (w_we && (w_rd != '0) && (w_rd == rs))
      sel = 2'b10;
    return sel;
  endfunction

  assign rs1_hit      = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit      = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use     = ex_mem_read && (ex_rd != '0) && (rs1_hit || rs2_hit);
  assign redirect_run = ex_redirect && !ex_mdu_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN: begin
        cnt_d = '0;
        if (ex_mdu_op) state_d = S_MDU_WAIT;
      end
      S_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = S_MDU_DRAIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_MDU_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MDU_DRAIN: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
    endcase
  end

  // Outputs are forced to their reset values combinationally so they respond to rst_n at once
  always_comb begin
    pc_sel      = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_flush = 1'b1;
    mdu_start   = 1'b0;
    fwd_a_sel   = 2'b00;
    fwd_b_sel   = 2'b00;
    if (rst_n) begin
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      fwd_a_sel   = fwd_sel(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      fwd_b_sel   = fwd_sel(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
      unique case (state_q)
        S_RUN: begin
          if (ex_mdu_op) begin
            mdu_start = 1'b1;
          end else if (redirect_run) begin
            pc_sel      = 1'b1;
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            id_ex_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
          end else if (load_use) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
          end else begin
            pc_en    = 1'b1;
            if_id_en = 1'b1;
            id_ex_en = 1'b1;
          end
        end
        S_MDU_WAIT: begin
        end
        S_MDU_DRAIN: begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          id_ex_en = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign mdu_err = err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_q, flush_q, mdu_q;
  logic        redirect_evt;

  assign redirect_evt = (state_q == S_RUN) && redirect_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
      mdu_q   <= '0;
    end else begin
      if (!pc_en)       stall_q <= stall_q + 32'd1;
      if (redirect_evt) flush_q <= flush_q + 32'd1;
      if (mdu_start)    mdu_q   <= mdu_q + 32'd1;
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_flush_cnt = flush_q;
  assign perf_mdu_cnt   = mdu_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized cycles against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int AW   = 5;
  localparam int MAXC = 40;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs1, id_rs2, ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_mdu_op, ex_redirect;
  logic          mem_reg_write, wb_reg_write, mdu_done;
  logic          pc_sel, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          mdu_start, mdu_err;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0]   perf_stall_cyc, perf_flush_cnt, perf_mdu_cnt;
`endif

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(AW), .MDU_MAX_CYC(MAXC)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mdu_op(ex_mdu_op), .ex_redirect(ex_redirect),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write), .mdu_done(mdu_done),
    .pc_sel(pc_sel), .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .mdu_start(mdu_start), .mdu_err(mdu_err)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_mdu_cnt(perf_mdu_cnt)
`endif
  );

  // {pc_sel, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mdu_start}
  wire [6:0] ctl = {pc_sel, pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, mdu_start};
  localparam logic [6:0] V_RST   = 7'b0000110;
  localparam logic [6:0] V_RUN   = 7'b0111000;
  localparam logic [6:0] V_LU    = 7'b0001010;
  localparam logic [6:0] V_RDR   = 7'b1111110;
  localparam logic [6:0] V_START = 7'b0000001;
  localparam logic [6:0] V_WAIT  = 7'b0000000;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic clear_inputs();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_mem_read = 0; ex_mdu_op = 0; ex_redirect = 0;
    ex_rs1 = '0; ex_rs2 = '0; mem_rd = '0; wb_rd = '0;
    mem_reg_write = 0; wb_reg_write = 0; mdu_done = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    ex_redirect = 1; ex_mem_read = 1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1;
    mem_rd = 5'd4; mem_reg_write = 1; ex_rs1 = 5'd4; ex_rs2 = 5'd4;
    @(negedge clk); #1;
    n_cmp++;
    if (ctl !== V_RST) begin n_fail++; $display("FAIL reset_ctl got=%b exp=%b", ctl, V_RST); end
    n_cmp++;
    if ({fwd_a_sel, fwd_b_sel, mdu_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_fwd_err got=%b exp=00000", {fwd_a_sel, fwd_b_sel, mdu_err});
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL post_reset_run got=%b exp=%b", ctl, V_RUN); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ex_rd = 5'd5; ex_mem_read = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_LU) begin n_fail++; $display("FAIL load_use_rs1 got=%b exp=%b", ctl, V_LU); end
    @(negedge clk);
    clear_inputs();
    id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL load_use_release got=%b exp=%b", ctl, V_RUN); end
    @(negedge clk);
    clear_inputs();
    ex_rd = 5'd9; ex_mem_read = 1; id_rs2 = 5'd9; id_use_rs2 = 1; id_rs1 = 5'd1; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_LU) begin n_fail++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, V_LU); end
  endtask

  task automatic test_x0_unused();
    @(negedge clk);
    clear_inputs();
    ex_rd = 5'd0; ex_mem_read = 1; id_rs1 = 5'd0; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL x0_no_stall got=%b exp=%b", ctl, V_RUN); end
    @(negedge clk);
    clear_inputs();
    ex_rd = 5'd6; ex_mem_read = 1; id_rs1 = 5'd6; id_rs2 = 5'd6;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL unused_no_stall got=%b exp=%b", ctl, V_RUN); end
    @(negedge clk);
    clear_inputs();
    ex_rd = 5'd6; id_rs1 = 5'd6; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL nonload_no_stall got=%b exp=%b", ctl, V_RUN); end
  endtask

  task automatic test_redirect();
    @(negedge clk);
    clear_inputs();
    ex_redirect = 1; ex_rd = 5'd5; ex_mem_read = 1; id_rs1 = 5'd5; id_use_rs1 = 1;
    #1;
    n_cmp++;
    if (ctl !== V_RDR) begin n_fail++; $display("FAIL redirect_over_lu got=%b exp=%b", ctl, V_RDR); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL after_redirect got=%b exp=%b", ctl, V_RUN); end
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    clear_inputs();
    mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 5'd7; ex_rs2 = 5'd3;
    #1;
    n_cmp++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0100) begin
      n_fail++; $display("FAIL fwd_mem_prio got=%b exp=0100", {fwd_a_sel, fwd_b_sel});
    end
    mem_reg_write = 0; ex_rs2 = 5'd7;
    #1;
    n_cmp++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b1010) begin
      n_fail++; $display("FAIL fwd_wb got=%b exp=1010", {fwd_a_sel, fwd_b_sel});
    end
    mem_rd = 5'd0; wb_rd = 5'd0; mem_reg_write = 1; wb_reg_write = 1; ex_rs1 = 5'd0; ex_rs2 = 5'd0;
    #1;
    n_cmp++;
    if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin
      n_fail++; $display("FAIL fwd_x0 got=%b exp=0000", {fwd_a_sel, fwd_b_sel});
    end
  endtask

  task automatic test_mdu();
    int low_cyc;
    low_cyc = 0;
    @(negedge clk);
    clear_inputs();
    ex_mdu_op = 1; ex_redirect = 0;
    #1;
    n_cmp++;
    if (ctl !== V_START) begin n_fail++; $display("FAIL mdu_start got=%b exp=%b", ctl, V_START); end
    if (pc_en == 0) low_cyc++;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      mdu_done = (i == 10);
      #1;
      n_cmp++;
      if (ctl !== V_WAIT) begin n_fail++; $display("FAIL mdu_wait%0d got=%b exp=%b", i, ctl, V_WAIT); end
      if (pc_en == 0) low_cyc++;
    end
    @(negedge clk);
    mdu_done = 0;
    #1;
    n_cmp++;
    if (ctl !== V_RUN) begin n_fail++; $display("FAIL mdu_drain got=%b exp=%b", ctl, V_RUN); end
    n_cmp++;
    if (low_cyc !== 11) begin n_fail++; $display("FAIL mdu_low_cycles got=%0d exp=11", low_cyc); end
    @(negedge clk);
    ex_mdu_op = 0;
    #1;
    n_cmp++;
    if ({ctl, mdu_err} !== {V_RUN, 1'b0}) begin
      n_fail++; $display("FAIL mdu_back_run got=%b exp=%b", {ctl, mdu_err}, {V_RUN, 1'b0});
    end
  endtask

  task automatic test_watchdog();
    @(negedge clk);
    clear_inputs();
    ex_mdu_op = 1;
    #1;
    n_cmp++;
    if (ctl !== V_START) begin n_fail++; $display("FAIL wd_start got=%b exp=%b", ctl, V_START); end
    for (int i = 0; i < MAXC; i++) begin
      @(negedge clk); #1;
      n_cmp++;
      if ({ctl, mdu_err} !== {V_WAIT, 1'b0}) begin
        n_fail++; $display("FAIL wd_wait%0d got=%b exp=%b", i, {ctl, mdu_err}, {V_WAIT, 1'b0});
      end
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({ctl, mdu_err} !== {V_RUN, 1'b1}) begin
      n_fail++; $display("FAIL wd_drain got=%b exp=%b", {ctl, mdu_err}, {V_RUN, 1'b1});
    end
    @(negedge clk);
    ex_mdu_op = 0;
    #1;
    n_cmp++;
    if ({ctl, mdu_err} !== {V_RUN, 1'b1}) begin
      n_fail++; $display("FAIL wd_sticky got=%b exp=%b", {ctl, mdu_err}, {V_RUN, 1'b1});
    end
  endtask

  task automatic test_reset_mid_mdu();
    @(negedge clk);
    clear_inputs();
    ex_mdu_op = 1;
    repeat (4) @(negedge clk);
    #1;
    n_cmp++;
    if (ctl !== V_WAIT) begin n_fail++; $display("FAIL rm_in_wait got=%b exp=%b", ctl, V_WAIT); end
    rst_n = 0;
    #1;
    n_cmp++;
    if ({ctl, fwd_a_sel, fwd_b_sel, mdu_err} !== {V_RST, 5'b0}) begin
      n_fail++; $display("FAIL rm_async got=%b exp=%b", {ctl, fwd_a_sel, fwd_b_sel, mdu_err}, {V_RST, 5'b0});
    end
    @(negedge clk);
    rst_n = 1;
    ex_mdu_op = 0;
    #1;
    n_cmp++;
    if ({ctl, mdu_err} !== {V_RUN, 1'b0}) begin
      n_fail++; $display("FAIL rm_back_run got=%b exp=%b", {ctl, mdu_err}, {V_RUN, 1'b0});
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [AW-1:0] rs);
    if (mem_reg_write && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic test_random();
    bit        busy, drain, err;
    int        age;
    bit        lu;
    logic [6:0] exp_ctl;
    logic [4:0] exp_rest;
    busy = 0; drain = 0; err = mdu_err;
    age = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      id_rs1 = AW'($urandom_range(0, 3)); id_rs2 = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3)); ex_rs1 = AW'($urandom_range(0, 3));
      ex_rs2 = AW'($urandom_range(0, 3)); mem_rd = AW'($urandom_range(0, 3));
      wb_rd = AW'($urandom_range(0, 3));
      id_use_rs1 = $urandom_range(0, 1) == 1; id_use_rs2 = $urandom_range(0, 1) == 1;
      mem_reg_write = $urandom_range(0, 1) == 1; wb_reg_write = $urandom_range(0, 1) == 1;
      ex_mem_read = $urandom_range(0, 2) == 0; ex_redirect = $urandom_range(0, 3) == 0;
      ex_mdu_op = $urandom_range(0, 15) == 0; mdu_done = $urandom_range(0, 7) == 0;
      #1;
      lu = ex_mem_read && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (drain)            exp_ctl = V_RUN;
      else if (busy)        exp_ctl = V_WAIT;
      else if (ex_mdu_op)   exp_ctl = V_START;
      else if (ex_redirect) exp_ctl = V_RDR;
      else if (lu)          exp_ctl = V_LU;
      else                  exp_ctl = V_RUN;
      exp_rest = {model_fwd(ex_rs1), model_fwd(ex_rs2), err};
      n_cmp++;
      if ({ctl, fwd_a_sel, fwd_b_sel, mdu_err} !== {exp_ctl, exp_rest}) begin
        n_fail++;
        $display("FAIL rand_cyc%0d got=%b exp=%b", c, {ctl, fwd_a_sel, fwd_b_sel, mdu_err}, {exp_ctl, exp_rest});
      end
      if (drain) begin
        drain = 0;
      end else if (busy) begin
        if (mdu_done) begin
          busy = 0; drain = 1;
        end else if (age == MAXC - 1) begin
          busy = 0; drain = 1; err = 1;
        end else begin
          age++;
        end
      end else if (ex_mdu_op) begin
        busy = 1; age = 0;
      end
    end
  endtask

  initial begin
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_load_use();
    test_x0_unused();
    test_redirect();
    test_forwarding();
    test_mdu();
    test_watchdog();
    test_reset_mid_mdu();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
